// File: rtl/alu_issue_ctrl_if.sv
// rtl/alu_issue_ctrl_if.sv - request, ALU and response signal bundle for alu_issue_ctrl
interface alu_issue_ctrl_if #(parameter int DATA_W = 32);
   logic              req_valid;
   logic              req_ready;
   logic [5:0]        req_opcode;
   logic [5:0]        req_funct;
   logic [DATA_W-1:0] req_a;
   logic [DATA_W-1:0] req_b;

   logic [3:0]        alu_operation;
   logic [DATA_W-1:0] operand_1;
   logic [DATA_W-1:0] operand_2;
   logic [DATA_W-1:0] alu_data_out;
   logic              alu_overflow;
   logic              alu_zero_flag;

   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_data;
   logic              rsp_overflow;
   logic              rsp_zero;
   logic              rsp_illegal;
   logic              busy;

   modport slave (
      input  req_valid, req_opcode, req_funct, req_a, req_b,
      input  alu_data_out, alu_overflow, alu_zero_flag, rsp_ready,
      output req_ready, alu_operation, operand_1, operand_2,
      output rsp_valid, rsp_data, rsp_overflow, rsp_zero, rsp_illegal, busy
   );

   modport master (
      output req_valid, req_opcode, req_funct, req_a, req_b,
      output alu_data_out, alu_overflow, alu_zero_flag, rsp_ready,
      input  req_ready, alu_operation, operand_1, operand_2,
      input  rsp_valid, rsp_data, rsp_overflow, rsp_zero, rsp_illegal, busy
   );
endinterface

// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - issues decoded MIPS ops to a combinational ALU, MULT by iterative shift-add
// Optional MUL_EARLY_EXIT_EN: MULT finishes as soon as no multiplier bits remain.
module alu_issue_ctrl #(
   parameter int DATA_W = 32
) (
   input logic             clk,
   input logic             reset,
   alu_issue_ctrl_if.slave bus
);

   localparam int                CNT_W    = $clog2(DATA_W + 1);
   localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(DATA_W - 1);

   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL, S_RESP} state_t;

   state_t            r_state;
   logic              r_req_ready;
   logic              r_busy;
   logic              r_rsp_valid;
   logic [DATA_W-1:0] r_rsp_data;
   logic              r_rsp_overflow;
   logic              r_rsp_zero;
   logic              r_rsp_illegal;
   logic [3:0]        r_alu_op;
   logic [DATA_W-1:0] r_op1;
   logic [DATA_W-1:0] r_op2;
   logic [DATA_W-1:0] r_mp;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_ovf;

   logic              w_legal;
   logic              w_mul;
   logic [3:0]        w_code;
   logic [DATA_W-1:0] w_op1;
   logic [DATA_W-1:0] w_op2;
   logic [DATA_W-1:0] w_mp_next;
   logic [DATA_W-1:0] w_acc_next;
   logic              w_ovf_next;
   logic              w_mul_done;

   always_comb begin
      w_legal = 1'b1;
      w_mul   = 1'b0;
      w_code  = 4'b0000;
      w_op1   = bus.req_a;
      w_op2   = bus.req_b;
      case (bus.req_opcode)
         6'b000000: begin
            case (bus.req_funct)
               6'b100000: w_code = 4'b0010;
               6'b100010: w_code = 4'b0110;
               6'b100111: begin
                  w_code = 4'b0011;
                  w_op1  = bus.req_a | bus.req_b;
                  w_op2  = '0;
               end
               6'b011000: w_mul = 1'b1;
               default:   w_legal = 1'b0;
            endcase
         end
         6'b001000: w_code  = 4'b0010;
         6'b000100: w_code  = 4'b0110;
         default:   w_legal = 1'b0;
      endcase
   end

   // In MUL the operand registers double as accumulator (op1) and shifted multiplicand (op2).
   assign w_mp_next  = r_mp >> 1;
   assign w_acc_next = r_mp[0] ? bus.alu_data_out : r_op1;
   assign w_ovf_next = r_ovf | (r_mp[0] & bus.alu_overflow);

`ifdef MUL_EARLY_EXIT_EN
   assign w_mul_done = (r_cnt == LAST_CNT) || (w_mp_next == '0);
`else
   assign w_mul_done = (r_cnt == LAST_CNT);
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state        <= S_IDLE;
         r_req_ready    <= 1'b1;
         r_busy         <= 1'b0;
         r_rsp_valid    <= 1'b0;
         r_rsp_data     <= '0;
         r_rsp_overflow <= 1'b0;
         r_rsp_zero     <= 1'b0;
         r_rsp_illegal  <= 1'b0;
         r_alu_op       <= 4'b0000;
         r_op1          <= '0;
         r_op2          <= '0;
         r_mp           <= '0;
         r_cnt          <= '0;
         r_ovf          <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.req_valid) begin
                  r_req_ready <= 1'b0;
                  r_busy      <= 1'b1;
                  r_mp        <= bus.req_b;
                  r_cnt       <= '0;
                  r_ovf       <= 1'b0;
                  if (!w_legal) begin
                     r_state        <= S_RESP;
                     r_rsp_valid    <= 1'b1;
                     r_rsp_illegal  <= 1'b1;
                     r_rsp_data     <= '0;
                     r_rsp_overflow <= 1'b0;
                     r_rsp_zero     <= 1'b0;
                  end else if (w_mul) begin
                     r_state  <= S_MUL;
                     r_alu_op <= 4'b0010;
                     r_op1    <= '0;
                     r_op2    <= bus.req_a;
                  end else begin
                     r_state  <= S_EXEC;
                     r_alu_op <= w_code;
                     r_op1    <= w_op1;
                     r_op2    <= w_op2;
                  end
               end
            end
            S_EXEC: begin
               r_state        <= S_RESP;
               r_rsp_valid    <= 1'b1;
               r_rsp_data     <= bus.alu_data_out;
               r_rsp_overflow <= bus.alu_overflow;
               r_rsp_zero     <= bus.alu_zero_flag;
               r_rsp_illegal  <= 1'b0;
               r_alu_op       <= 4'b0000;
               r_op1          <= '0;
               r_op2          <= '0;
            end
            S_MUL: begin
               r_mp  <= w_mp_next;
               r_cnt <= r_cnt + 1'b1;
               r_ovf <= w_ovf_next;
               if (w_mul_done) begin
                  r_state        <= S_RESP;
                  r_rsp_valid    <= 1'b1;
                  r_rsp_data     <= w_acc_next;
                  r_rsp_overflow <= w_ovf_next;
                  r_rsp_zero     <= (w_acc_next == '0);
                  r_rsp_illegal  <= 1'b0;
                  r_alu_op       <= 4'b0000;
                  r_op1          <= '0;
                  r_op2          <= '0;
               end else begin
                  r_op1 <= w_acc_next;
                  r_op2 <= r_op2 << 1;
               end
            end
            S_RESP: begin
               if (bus.rsp_ready) begin
                  r_state        <= S_IDLE;
                  r_req_ready    <= 1'b1;
                  r_busy         <= 1'b0;
                  r_rsp_valid    <= 1'b0;
                  r_rsp_data     <= '0;
                  r_rsp_overflow <= 1'b0;
                  r_rsp_zero     <= 1'b0;
                  r_rsp_illegal  <= 1'b0;
               end
            end
            default: begin
               r_state     <= S_IDLE;
               r_req_ready <= 1'b1;
               r_busy      <= 1'b0;
               r_rsp_valid <= 1'b0;
            end
         endcase
      end
   end

   assign bus.req_ready     = r_req_ready;
   assign bus.busy          = r_busy;
   assign bus.rsp_valid     = r_rsp_valid;
   assign bus.rsp_data      = r_rsp_data;
   assign bus.rsp_overflow  = r_rsp_overflow;
   assign bus.rsp_zero      = r_rsp_zero;
   assign bus.rsp_illegal   = r_rsp_illegal;
   assign bus.alu_operation = r_alu_op;
   assign bus.operand_1     = r_op1;
   assign bus.operand_2     = r_op2;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - self-checking bench for alu_issue_ctrl with ALU stub and reference model
module tb_alu_issue_ctrl;
   localparam int DATA_W = 32;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   alu_issue_ctrl_if #(.DATA_W(DATA_W)) bus ();
   alu_issue_ctrl #(.DATA_W(DATA_W)) dut (.clk(clk), .reset(reset), .bus(bus));

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   function automatic logic add_ovf(input logic [DATA_W-1:0] x, y, s);
      return (x[DATA_W-1] == y[DATA_W-1]) && (s[DATA_W-1] != x[DATA_W-1]);
   endfunction

   function automatic logic sub_ovf(input logic [DATA_W-1:0] x, y, d);
      return (x[DATA_W-1] != y[DATA_W-1]) && (d[DATA_W-1] != x[DATA_W-1]);
   endfunction

   // Combinational ALU stand-in
   logic [DATA_W-1:0] alu_res;
   logic              alu_ovf;
   always_comb begin
      alu_res = '0;
      alu_ovf = 1'b0;
      case (bus.alu_operation)
         4'b0000: alu_res = bus.operand_1 & bus.operand_2;
         4'b0001: alu_res = bus.operand_1 | bus.operand_2;
         4'b0010: begin
            alu_res = bus.operand_1 + bus.operand_2;
            alu_ovf = add_ovf(bus.operand_1, bus.operand_2, alu_res);
         end
         4'b0110: begin
            alu_res = bus.operand_1 - bus.operand_2;
            alu_ovf = sub_ovf(bus.operand_1, bus.operand_2, alu_res);
         end
         4'b0011: alu_res = ~(bus.operand_1 | bus.operand_2);
         default: alu_res = '0;
      endcase
   end
   assign bus.alu_data_out  = alu_res;
   assign bus.alu_overflow  = alu_ovf;
   assign bus.alu_zero_flag = (alu_res == '0);

   // Reference model: one outstanding transaction with predicted results and timing
   bit                m_pending = 1'b0;
   int                m_acc_cyc = 0;
   int                m_valid_cyc = 0;
   logic [DATA_W-1:0] m_data, m_o1, m_o2;
   logic              m_ovf, m_zero, m_ill, m_mul;
   logic [3:0]        m_code;

   task automatic predict(input logic [5:0] op, fn, input logic [DATA_W-1:0] a, b);
      logic [DATA_W-1:0] acc, term;
      int lat;
      m_ill = 1'b0; m_mul = 1'b0; m_ovf = 1'b0; m_o1 = a; m_o2 = b; m_code = 4'b0000; lat = 2;
      if ((op == 6'h00 && fn == 6'h20) || op == 6'h08) begin
         m_code = 4'b0010; m_data = a + b; m_ovf = add_ovf(a, b, m_data);
      end else if ((op == 6'h00 && fn == 6'h22) || op == 6'h04) begin
         m_code = 4'b0110; m_data = a - b; m_ovf = sub_ovf(a, b, m_data);
      end else if (op == 6'h00 && fn == 6'h27) begin
         m_code = 4'b0011; m_data = ~(a | b); m_o1 = a | b; m_o2 = '0;
      end else if (op == 6'h00 && fn == 6'h18) begin
         m_mul = 1'b1; m_code = 4'b0010; m_o1 = '0; m_o2 = a; acc = '0;
         for (int i = 0; i < DATA_W; i++) begin
            if (b[i]) begin
               term  = a << i;
               m_ovf = m_ovf | add_ovf(acc, term, acc + term);
               acc   = acc + term;
            end
         end
         m_data = acc;
`ifdef MUL_EARLY_EXIT_EN
         lat = 1;
         for (int i = 0; i < DATA_W; i++) if (b[i]) lat = i + 1;
         lat = lat + 1;
`else
         lat = DATA_W + 1;
`endif
      end else begin
         m_ill = 1'b1; m_data = '0; lat = 1;
      end
      m_zero      = (m_data == '0);
      m_valid_cyc = cyc + lat;
   endtask

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_pending = 1'b0;
      end else begin
         if (m_pending) begin
            if (cyc >= m_valid_cyc && bus.rsp_ready) m_pending = 1'b0;
         end else if (bus.req_valid) begin
            predict(bus.req_opcode, bus.req_funct, bus.req_a, bus.req_b);
            m_acc_cyc = cyc;
            m_pending = 1'b1;
         end
         cyc++;
      end
   end

   task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Per-cycle comparison against the model
   always @(negedge clk) begin
      if (reset) begin
         chk("rst_rsp_valid", bus.rsp_valid, 0);
         chk("rst_busy", bus.busy, 0);
         chk("rst_req_ready", bus.req_ready, 1);
         chk("rst_alu_op", bus.alu_operation, 0);
         chk("rst_operand_1", bus.operand_1, 0);
         chk("rst_rsp_data", bus.rsp_data, 0);
      end else if (!m_pending) begin
         chk("idle_req_ready", bus.req_ready, 1);
         chk("idle_busy", bus.busy, 0);
         chk("idle_rsp_valid", bus.rsp_valid, 0);
         chk("idle_alu_op", bus.alu_operation, 0);
      end else if (cyc < m_valid_cyc) begin
         chk("run_req_ready", bus.req_ready, 0);
         chk("run_busy", bus.busy, 1);
         chk("run_rsp_valid", bus.rsp_valid, 0);
         chk("run_alu_op", bus.alu_operation, m_code);
         if (cyc == m_acc_cyc + 1) begin
            chk("run_operand_1", bus.operand_1, m_o1);
            chk("run_operand_2", bus.operand_2, m_o2);
         end
      end else begin
         chk("rsp_valid", bus.rsp_valid, 1);
         chk("rsp_req_ready", bus.req_ready, 0);
         chk("rsp_busy", bus.busy, 1);
         chk("rsp_alu_op", bus.alu_operation, 0);
         chk("rsp_data", bus.rsp_data, m_data);
         chk("rsp_illegal", bus.rsp_illegal, m_ill);
         if (!m_ill) begin
            chk("rsp_overflow", bus.rsp_overflow, m_ovf);
            chk("rsp_zero", bus.rsp_zero, m_zero);
         end
      end
   end

   task automatic send(input logic [5:0] op, fn, input logic [DATA_W-1:0] a, b);
      bus.req_opcode = op; bus.req_funct = fn; bus.req_a = a; bus.req_b = b;
      bus.req_valid  = 1'b1;
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
   endtask

   task automatic get_rsp(input string name, input logic [DATA_W-1:0] d, input logic ovf, zero, ill,
                          input int lat, input int hold, input bit overlap);
      int n = 0;
      do begin @(negedge clk); n++; end while (bus.rsp_valid !== 1'b1 && n < 200);
      if (bus.rsp_valid !== 1'b1) begin
         chk({name, "_timeout"}, bus.rsp_valid, 1);
      end else begin
         chk({name, "_lat"}, cyc - m_acc_cyc, lat);
         chk({name, "_data"}, bus.rsp_data, d);
         chk({name, "_illegal"}, bus.rsp_illegal, ill);
         if (!ill) begin
            chk({name, "_ovf"}, bus.rsp_overflow, ovf);
            chk({name, "_zero"}, bus.rsp_zero, zero);
         end
         repeat (hold) begin
            @(negedge clk);
            chk({name, "_hold_data"}, bus.rsp_data, d);
            chk({name, "_hold_ready"}, bus.req_ready, 0);
         end
      end
      if (overlap) bus.req_valid = 1'b1;
      bus.rsp_ready = 1'b1;
      @(posedge clk);
      #1 bus.rsp_ready = 1'b0;
      if (overlap) begin
         @(posedge clk);
         #1 bus.req_valid = 1'b0;
      end
   endtask

   initial begin
      bus.req_valid = 1'b0; bus.req_opcode = '0; bus.req_funct = '0;
      bus.req_a = '0; bus.req_b = '0; bus.rsp_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);

      send(6'h00, 6'h20, 32'd5, 32'd7);
      get_rsp("add", 32'd12, 0, 0, 0, 2, 0, 0);
      send(6'h00, 6'h22, 32'd9, 32'd9);
      get_rsp("sub", 32'd0, 0, 1, 0, 2, 0, 0);
      send(6'h04, 6'h00, 32'd3, 32'd4);
      get_rsp("beq", 32'hFFFF_FFFF, 0, 0, 0, 2, 0, 0);
      send(6'h00, 6'h27, 32'h0F0F_0000, 32'h0000_00FF);
      get_rsp("nor", 32'hF0F0_FF00, 0, 0, 0, 2, 0, 0);
      send(6'h08, 6'h00, 32'h7FFF_FFFF, 32'd1);
      get_rsp("addi_ovf", 32'h8000_0000, 1, 0, 0, 2, 0, 0);
`ifdef MUL_EARLY_EXIT_EN
      send(6'h00, 6'h18, 32'd6, 32'd7);
      get_rsp("mult_6x7", 32'd42, 0, 0, 0, 4, 0, 0);
      send(6'h00, 6'h18, 32'hFFFF_FFFF, 32'd2);
      get_rsp("mult_neg", 32'hFFFF_FFFE, 0, 0, 0, 3, 0, 0);
      send(6'h00, 6'h18, 32'd12345, 32'd0);
      get_rsp("mult_zero", 32'd0, 0, 1, 0, 2, 0, 0);
      send(6'h00, 6'h18, 32'h3000_0000, 32'd3);
      get_rsp("mult_ovf", 32'h9000_0000, 1, 0, 0, 3, 0, 0);
`else
      send(6'h00, 6'h18, 32'd6, 32'd7);
      get_rsp("mult_6x7", 32'd42, 0, 0, 0, 33, 0, 0);
      send(6'h00, 6'h18, 32'hFFFF_FFFF, 32'd2);
      get_rsp("mult_neg", 32'hFFFF_FFFE, 0, 0, 0, 33, 0, 0);
      send(6'h00, 6'h18, 32'd12345, 32'd0);
      get_rsp("mult_zero", 32'd0, 0, 1, 0, 33, 0, 0);
      send(6'h00, 6'h18, 32'h3000_0000, 32'd3);
      get_rsp("mult_ovf", 32'h9000_0000, 1, 0, 0, 33, 0, 0);
`endif
      send(6'h3F, 6'h00, 32'd1, 32'd2);
      get_rsp("illegal_op", 32'd0, 0, 0, 1, 1, 0, 0);
      send(6'h00, 6'h25, 32'd1, 32'd2);
      get_rsp("illegal_funct", 32'd0, 0, 0, 1, 1, 0, 0);

      // Backpressure, with the next request already waiting during the response handshake
      send(6'h00, 6'h20, 32'd100, 32'd23);
      bus.req_opcode = 6'h00; bus.req_funct = 6'h22; bus.req_a = 32'd9; bus.req_b = 32'd9;
      get_rsp("backpressure", 32'd123, 0, 0, 0, 2, 5, 1);
      get_rsp("after_bp_sub", 32'd0, 0, 1, 0, 2, 0, 0);

      // Reset in the middle of a multiply
      send(6'h00, 6'h18, 32'd3, 32'h8000_0001);
      repeat (9) @(posedge clk);
      #1 reset = 1'b1;
      #1 chk("midmul_busy", bus.busy, 0);
      chk("midmul_rsp_valid", bus.rsp_valid, 0);
      chk("midmul_req_ready", bus.req_ready, 1);
      @(negedge clk);
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("post_rst_rsp_valid", bus.rsp_valid, 0);
      send(6'h00, 6'h20, 32'd1, 32'd1);
      get_rsp("post_rst_add", 32'd2, 0, 0, 0, 2, 0, 0);

      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
      $fatal(1, "watchdog expired");
   end

endmodule
